// File: rtl/wb_queue_pkg.sv
// Shared write-back queue types and machine-width defines (N_WAY, CDB_BITS, XLEN, N_PHY_REG).
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef N_PHY_REG
`define N_PHY_REG 64
`endif
`ifndef CDB_BITS
`define CDB_BITS 7
`endif

package wb_queue_pkg;

  localparam int unsigned N_WAY         = `N_WAY;
  localparam int unsigned XLEN          = `XLEN;
  localparam int unsigned N_PHY_REG     = `N_PHY_REG;
  localparam int unsigned CDB_BITS      = `CDB_BITS;
  localparam int unsigned PR_BITS       = $clog2(N_PHY_REG) + 1;
  localparam int unsigned WBQ_DEPTH_DEF = 8;

  typedef logic [CDB_BITS-1:0] tag_t;
  typedef logic [XLEN-1:0]     data_t;

  typedef struct packed {
    tag_t  tag;
    data_t data;
  } wbq_entry_t;

  // Number of asserted regfile write enables in one cycle.
  function automatic int unsigned popcount_way(input logic [N_WAY-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(N_WAY); i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/wb_queue_if.sv
// FU result ports and regfile/CDB write ports of the write-back queue.
interface wb_queue_if
  import wb_queue_pkg::*;
#(
  parameter int unsigned N_FU = 4
);

  logic [N_FU-1:0]         fu_valid;
  tag_t  [N_FU-1:0]        fu_tag;
  data_t [N_FU-1:0]        fu_data;
  logic [N_FU-1:0]         fu_ready;
  logic [N_WAY-1:0]        wr_en;
  tag_t  [N_WAY-1:0]       wr_idx;
  data_t [N_WAY-1:0]       wr_data;

  modport master (
    output fu_valid, fu_tag, fu_data,
    input  fu_ready, wr_en, wr_idx, wr_data
  );

  modport slave (
    input  fu_valid, fu_tag, fu_data,
    output fu_ready, wr_en, wr_idx, wr_data
  );

endinterface

// File: rtl/wbq_fifo_mem.sv
// Entry storage for the write-back queue: N_WR write ports, N_RD combinational read ports.
module wbq_fifo_mem
  import wb_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned N_WR  = 4,
  parameter  int unsigned N_RD  = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                       clock,
  input  logic [N_WR-1:0]            we,
  input  logic [N_WR-1:0][AW-1:0]    waddr,
  input  wbq_entry_t [N_WR-1:0]      wdata,
  input  logic [N_RD-1:0][AW-1:0]    raddr,
  output wbq_entry_t [N_RD-1:0]      rdata_c
);

  wbq_entry_t mem [DEPTH];

  // Write addresses are distinct by construction (consecutive slots from tail).
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(N_WR); i++) begin
      if (we[i]) mem[waddr[i]] <= wdata[i];
    end
  end

  always_comb begin
    rdata_c = '0;
    for (int k = 0; k < int'(N_RD); k++) rdata_c[k] = mem[raddr[k]];
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: buffers FU results, issues up to N_WAY regfile writes per cycle.
// Optional WBQ_STATS_EN adds stall_cycles / writes_total counters.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter  int unsigned N_FU      = 4,
  parameter  int unsigned WBQ_DEPTH = WBQ_DEPTH_DEF,
  localparam int unsigned AW        = $clog2(WBQ_DEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [PR_BITS-1:0] zero_reg_pr,
  wb_queue_if.slave          bus,
  output logic [CW-1:0]      wbq_count
`ifdef WBQ_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        writes_total
`endif
);

  logic [AW-1:0]                head;
  logic [AW-1:0]                tail;
  logic                         ready_c;
  logic [N_FU-1:0]              accept_c;
  logic [N_FU-1:0][AW-1:0]      waddr_c;
  wbq_entry_t [N_FU-1:0]        wdata_c;
  logic [CW-1:0]                enq_cnt_c;
  logic [CW-1:0]                deq_cnt_c;
  logic [N_WAY-1:0][AW-1:0]     raddr_c;
  wbq_entry_t [N_WAY-1:0]       rdata_c;

  // All-or-nothing acceptance: room for every FU port, and never during flush.
  assign ready_c      = ((CW'(WBQ_DEPTH) - wbq_count) >= CW'(N_FU)) && !flush;
  assign bus.fu_ready = {N_FU{ready_c}};
  assign accept_c     = bus.fu_valid & {N_FU{ready_c}};

  // Accepted ports pack into consecutive slots from tail in ascending port order.
  always_comb begin
    enq_cnt_c = '0;
    waddr_c   = '0;
    wdata_c   = '0;
    for (int i = 0; i < int'(N_FU); i++) begin
      waddr_c[i]      = tail + AW'(enq_cnt_c);
      wdata_c[i].tag  = bus.fu_tag[i];
      wdata_c[i].data = bus.fu_data[i];
      if (accept_c[i]) enq_cnt_c = enq_cnt_c + CW'(1);
    end
  end

  always_comb begin
    deq_cnt_c = (wbq_count > CW'(N_WAY)) ? CW'(N_WAY) : wbq_count;
    raddr_c   = '0;
    for (int k = 0; k < int'(N_WAY); k++) raddr_c[k] = head + AW'(k);
  end

  wbq_fifo_mem #(
    .DEPTH (WBQ_DEPTH),
    .N_WR  (N_FU),
    .N_RD  (N_WAY)
  ) u_mem (
    .clock   (clock),
    .we      (accept_c & {N_FU{!reset}}),
    .waddr   (waddr_c),
    .wdata   (wdata_c),
    .raddr   (raddr_c),
    .rdata_c (rdata_c)
  );

  // Pointers, occupancy and registered write ports; reset over flush over enq/deq.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head        <= '0;
      tail        <= '0;
      wbq_count   <= '0;
      bus.wr_en   <= '0;
      bus.wr_idx  <= '0;
      bus.wr_data <= '0;
    end else begin
      head      <= head + AW'(deq_cnt_c);
      tail      <= tail + AW'(enq_cnt_c);
      wbq_count <= wbq_count + enq_cnt_c - deq_cnt_c;
      for (int k = 0; k < int'(N_WAY); k++) begin
        if (CW'(k) < deq_cnt_c) begin
          bus.wr_en[k]   <= (rdata_c[k].tag != CDB_BITS'(zero_reg_pr));
          bus.wr_idx[k]  <= rdata_c[k].tag;
          bus.wr_data[k] <= rdata_c[k].data;
        end else begin
          bus.wr_en[k]   <= 1'b0;
          bus.wr_idx[k]  <= '0;
          bus.wr_data[k] <= '0;
        end
      end
    end
  end

`ifdef WBQ_STATS_EN
  logic [32:0] writes_sum_c;

  assign writes_sum_c = {1'b0, writes_total} + 33'(popcount_way(bus.wr_en));

  // Saturating counters; flush does not clear them.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      writes_total <= '0;
    end else begin
      if ((|bus.fu_valid) && !ready_c && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      writes_total <= writes_sum_c[32] ? '1 : writes_sum_c[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: queue-based reference model plus directed literal checks.
module tb_wb_queue;
  import wb_queue_pkg::*;

  localparam int unsigned NF  = 4;
  localparam int unsigned DEP = 8;
  localparam int          ZR  = 45;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               flush = 1'b0;
  logic [PR_BITS-1:0] zero_reg_pr = PR_BITS'(ZR);
  logic [3:0]         wbq_count;
`ifdef WBQ_STATS_EN
  logic [31:0]        stall_cycles;
  logic [31:0]        writes_total;
`endif

  wb_queue_if #(.N_FU(NF)) bus ();

  wb_queue #(.N_FU(NF), .WBQ_DEPTH(DEP)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .zero_reg_pr  (zero_reg_pr),
    .bus          (bus),
    .wbq_count    (wbq_count)
`ifdef WBQ_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .writes_total (writes_total)
`endif
  );

  always #5 clock = ~clock;

  // Reference model state: a plain queue of entries and the expected registered outputs.
  wbq_entry_t  mq[$];
  logic [1:0]  exp_en   = '0;
  tag_t        exp_idx  [2];
  data_t       exp_data [2];
  int          exp_cnt  = 0;
  int unsigned exp_stall  = 0;
  int unsigned exp_writes = 0;
  bit          chk_en = 1'b0;

  logic [3:0]  in_v;
  tag_t        in_t [4];
  data_t       in_d [4];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison of all registered outputs against the model.
  always @(posedge clock) begin
    #2;
    if (chk_en) begin
      check("count", longint'(wbq_count), longint'(exp_cnt));
      for (int k = 0; k < 2; k++) begin
        check("wr_en",   longint'(bus.wr_en[k]),   longint'(exp_en[k]));
        check("wr_idx",  longint'(bus.wr_idx[k]),  longint'(exp_idx[k]));
        check("wr_data", longint'(bus.wr_data[k]), longint'(exp_data[k]));
      end
`ifdef WBQ_STATS_EN
      check("stall_cycles", longint'(stall_cycles), longint'(exp_stall));
      check("writes_total", longint'(writes_total), longint'(exp_writes));
`endif
    end
  end

  task automatic set_in(input logic [3:0] v, input int t0, input int t1, input int t2, input int t3);
    int t[4];
    t = '{t0, t1, t2, t3};
    in_v = v;
    for (int i = 0; i < 4; i++) begin
      in_t[i] = tag_t'(t[i]);
      in_d[i] = 32'h1000 + 32'(t[i]);
    end
  endtask

  // Drive one cycle of inputs, check fu_ready, advance the model, return after the edge.
  task automatic step(input bit rst, input bit fl);
    bit         rdy;
    int         n;
    wbq_entry_t e;
    @(negedge clock);
    reset = rst;
    flush = fl;
    bus.fu_valid = in_v;
    for (int i = 0; i < 4; i++) begin
      bus.fu_tag[i]  = in_t[i];
      bus.fu_data[i] = in_d[i];
    end
    #1;
    rdy = !fl && ((int'(DEP) - mq.size()) >= int'(NF));
    if (chk_en && !rst) check("fu_ready", longint'(bus.fu_ready), rdy ? 64'hF : 64'h0);
    if (rst) begin
      exp_stall  = 0;
      exp_writes = 0;
    end else begin
      if ((|in_v) && !rdy) exp_stall++;
      exp_writes += $countones(exp_en);
    end
    if (rst || fl) begin
      mq.delete();
      exp_en = '0;
      for (int k = 0; k < 2; k++) begin
        exp_idx[k]  = '0;
        exp_data[k] = '0;
      end
    end else begin
      n = (mq.size() < 2) ? mq.size() : 2;
      for (int k = 0; k < 2; k++) begin
        if (k < n) begin
          e = mq.pop_front();
          exp_en[k]   = (int'(e.tag) != ZR);
          exp_idx[k]  = e.tag;
          exp_data[k] = e.data;
        end else begin
          exp_en[k]   = 1'b0;
          exp_idx[k]  = '0;
          exp_data[k] = '0;
        end
      end
      if (rdy) begin
        for (int i = 0; i < 4; i++) begin
          if (in_v[i]) mq.push_back('{tag: in_t[i], data: in_d[i]});
        end
      end
    end
    exp_cnt = mq.size();
    @(posedge clock);
    #3;
  endtask

  task automatic idle();
    set_in(4'b0000, 0, 0, 0, 0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(4'b0000, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      exp_idx[k]  = '0;
      exp_data[k] = '0;
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk_en = 1'b1;
    check("rst_count", longint'(wbq_count), 0);
    check("rst_wr_en", longint'(bus.wr_en), 0);

    // Single result
    set_in(4'b0001, 7, 0, 0, 0);
    in_d[0] = 32'hAB;
    step(1'b0, 1'b0);
    check("single_count", longint'(wbq_count), 1);
    idle();
    check("single_wr_en",   longint'(bus.wr_en), 1);
    check("single_wr_idx",  longint'(bus.wr_idx[0]), 7);
    check("single_wr_data", longint'(bus.wr_data[0]), 'hAB);
    idle();
    check("single_wr_en_off", longint'(bus.wr_en), 0);

    // Burst of four, drained two per cycle
    set_in(4'b1111, 1, 2, 3, 4);
    step(1'b0, 1'b0);
    check("burst_count4", longint'(wbq_count), 4);
    idle();
    check("burst_idx0_a", longint'(bus.wr_idx[0]), 1);
    check("burst_idx1_a", longint'(bus.wr_idx[1]), 2);
    check("burst_count2", longint'(wbq_count), 2);
    idle();
    check("burst_idx0_b", longint'(bus.wr_idx[0]), 3);
    check("burst_idx1_b", longint'(bus.wr_idx[1]), 4);
    check("burst_count0", longint'(wbq_count), 0);

    // x0 destination is consumed without a write
    set_in(4'b0011, 45, 46, 0, 0);
    step(1'b0, 1'b0);
    check("zr_count2", longint'(wbq_count), 2);
    idle();
    check("zr_wr_en",   longint'(bus.wr_en), 2);
    check("zr_wr_idx1", longint'(bus.wr_idx[1]), 46);
    check("zr_count0",  longint'(wbq_count), 0);

    // Backpressure and wrap-around
    set_in(4'b1111, 10, 11, 12, 13);
    step(1'b0, 1'b0);
    set_in(4'b1111, 14, 15, 16, 17);
    step(1'b0, 1'b0);
    check("bp_count6", longint'(wbq_count), 6);
    set_in(4'b1111, 18, 19, 20, 21);
    step(1'b0, 1'b0);
    check("bp_count_stalled", longint'(wbq_count), 4);
    step(1'b0, 1'b0);
    check("bp_idx0", longint'(bus.wr_idx[0]), 14);
    check("bp_idx1", longint'(bus.wr_idx[1]), 15);
    idle();
    idle();
    idle();
    check("bp_tail_idx0", longint'(bus.wr_idx[0]), 20);
    check("bp_tail_idx1", longint'(bus.wr_idx[1]), 21);
    check("bp_empty", longint'(wbq_count), 0);

    // Flush with six queued
    set_in(4'b1111, 30, 31, 32, 33);
    step(1'b0, 1'b0);
    set_in(4'b1111, 34, 35, 36, 37);
    step(1'b0, 1'b0);
    check("fl_count6", longint'(wbq_count), 6);
    set_in(4'b1111, 38, 39, 40, 41);
    step(1'b0, 1'b1);
    check("fl_count0", longint'(wbq_count), 0);
    check("fl_wr_en",  longint'(bus.wr_en), 0);
    idle();
    check("fl_no_write", longint'(bus.wr_en), 0);

    // Reset mid-drain
    set_in(4'b1111, 50, 51, 52, 53);
    step(1'b0, 1'b0);
    set_in(4'b1111, 54, 55, 56, 57);
    step(1'b0, 1'b0);
    idle();
    set_in(4'b1111, 58, 59, 60, 61);
    step(1'b1, 1'b0);
    check("rs_count0", longint'(wbq_count), 0);
    check("rs_wr_en",  longint'(bus.wr_en), 0);
`ifdef WBQ_STATS_EN
    check("rs_stall",  longint'(stall_cycles), 0);
    check("rs_writes", longint'(writes_total), 0);
`endif
    set_in(4'b0001, 9, 0, 0, 0);
    step(1'b0, 1'b0);
    idle();
    check("rs_first_en",  longint'(bus.wr_en), 1);
    check("rs_first_idx", longint'(bus.wr_idx[0]), 9);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_v = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        in_t[i] = ($urandom_range(0, 7) == 0) ? tag_t'(ZR) : tag_t'($urandom_range(0, 63));
        in_d[i] = $urandom;
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 31) == 0);
    end
    for (int c = 0; c < 6; c++) idle();
    check("final_empty", longint'(wbq_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The module SHALL have parameter N_FU, default 4, giving the number of functional-unit result ports.
REQ-002 The module SHALL have parameter WBQ_DEPTH, default 8 (power of two, at least N_FU + `N_WAY), giving the number of queue entries.
REQ-003 The module SHALL have these ports, clock and reset first:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  squash all queued results (mispredict).
- zero_reg_pr  input  $clog2(`N_PHY_REG)+1  physical tag of architectural x0.
- fu_valid  input  [N_FU]  result present on FU port i.
- fu_tag  input  [N_FU][`CDB_BITS]  destination physical register.
- fu_data  input  [N_FU][`XLEN]  result value.
- fu_ready  output  [N_FU]  queue accepts port i this cycle.
- wr_en  output  [`N_WAY]  regfile write enable / CDB valid.
- wr_idx  output  [`N_WAY][`CDB_BITS]  regfile write index / CDB tag.
- wr_data  output  [`N_WAY][`XLEN]  regfile write data.
- wbq_count  output  $clog2(WBQ_DEPTH)+1  current occupancy.

Function
REQ-004 The module SHALL be the writer for the N_WAY-port physical regfile: it buffers FU results and issues up to `N_WAY regfile writes per cycle.
REQ-005 Storage SHALL be a circular FIFO with head/tail pointers that wrap modulo WBQ_DEPTH, plus an occupancy count.
REQ-006 fu_ready SHALL be all-ones when (WBQ_DEPTH - wbq_count) >= N_FU and flush is low; otherwise it SHALL be all-zeros; it SHALL depend only on registered state and flush.
REQ-007 A port SHALL be enqueued only when fu_valid[i] && fu_ready[i]; same-cycle accepted ports SHALL be enqueued in ascending port index.
REQ-008 Each cycle the module SHALL dequeue min(count, `N_WAY) oldest entries, using count at the start of the cycle.
REQ-009 Dequeued entry k SHALL drive registered wr_idx[k] and wr_data[k] on the next cycle; an accepted result SHALL reach the write ports no earlier than one cycle after acceptance (latency 1 when the queue is empty).
REQ-010 wr_en[k] SHALL be 1 only for dequeued slots whose tag != zero_reg_pr; x0-tagged entries SHALL be consumed with wr_en[k]=0.
REQ-011 Unused write slots SHALL drive wr_en=0, wr_idx=0 and wr_data=0.
REQ-012 Same-cycle enqueue and dequeue SHALL both take effect: next count = count + enq - deq, never exceeding WBQ_DEPTH.
REQ-013 FIFO order SHALL be preserved across pointer wrap-around.
REQ-014 Flush SHALL empty the queue, drive wr_en to all-zeros on the next cycle, drop same-cycle inputs, and take priority over enqueue and dequeue.

Reset
REQ-015 Reset SHALL set head=0, tail=0, wbq_count=0, wr_en=0, wr_idx=0 and wr_data=0; it SHALL take priority over flush.
REQ-016 Reset asserted mid-operation SHALL discard all entries, and the first write after deassertion SHALL come only from post-reset input.

Configuration
REQ-017 When WBQ_STATS_EN is defined, the module SHALL add 32-bit outputs stall_cycles and writes_total.
- stall_cycles increments each cycle any fu_valid is 1 while fu_ready is 0.
- writes_total adds popcount(wr_en) each cycle.
- Both clear on reset (not on flush) and saturate at all-ones.
REQ-018 When WBQ_STATS_EN is undefined, those ports and counters SHALL not exist and behaviour SHALL otherwise be identical.

Structure
REQ-019 Entry typedef wbq_entry_t {tag, data} and the WBQ_DEPTH default SHALL live in the shared package, alongside `N_WAY, `CDB_BITS, `XLEN and `N_PHY_REG.
REQ-020 A sub-module wbq_fifo_mem, holding the entry array with N_FU write ports and `N_WAY read ports, SHALL be instantiated once.

Verification (bench: `N_WAY=2, N_FU=4, WBQ_DEPTH=8, zero_reg_pr=45)
REQ-021 Single result: after reset, fu_valid=0001, tag=7, data=0xAB for one cycle -> next cycle wr_en=01, wr_idx[0]=7, wr_data[0]=0xAB; following cycle wr_en=00.
REQ-022 Burst ordering: 4 results (tags 1..4) in cycle 0 -> cycle 1 writes tags 1,2; cycle 2 writes tags 3,4; wbq_count goes 4,2,0.
REQ-023 Full/backpressure: fu_valid=1111 for 3 consecutive cycles -> fu_ready drops when free < 4; no entry lost; tags drain in FIFO order, including across pointer wrap.
REQ-024 Zero register: tag 45 then tag 46 accepted together -> one cycle with wr_en=10, wr_idx[1]=46; count decrements by 2.
REQ-025 Flush/reset: assert flush with count=6 -> next cycle wbq_count=0, wr_en=00. Repeat with reset mid-drain -> same result, plus stats counters at 0 when WBQ_STATS_EN is defined.
